// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by synchronized slow_clk rising edges.
// Optional lap/hold display freeze is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_bcd #(
  parameter int SYNC_STAGES   = 2,
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_hist;
  logic                   start_hist;
  logic                   clear_hist;
  logic [PW-1:0]          presc;
  logic [3:0]             live_so, live_st, live_mo, live_mt;
  logic [3:0]             inc_so, inc_st, inc_mo, inc_mt;
  logic                   inc_wrap;
  logic                   tick, start_edge, clear_edge;

  assign tick       = sync_q[SYNC_STAGES-1] & ~tick_hist;
  assign start_edge = start_stop & ~start_hist;
  assign clear_edge = clear & ~clear_hist;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      tick_hist  <= 1'b0;
      start_hist <= 1'b0;
      clear_hist <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      tick_hist  <= sync_q[SYNC_STAGES-1];
      start_hist <= start_stop;
      clear_hist <= clear;
    end
  end

  // BCD ripple increment of the live time; inc_wrap marks 59:59 -> 00:00.
  always_comb begin
    inc_so   = live_so + 4'd1;
    inc_st   = live_st;
    inc_mo   = live_mo;
    inc_mt   = live_mt;
    inc_wrap = 1'b0;
    if (live_so == 4'd9) begin
      inc_so = 4'd0;
      if (live_st == 4'd5) begin
        inc_st = 4'd0;
        if (live_mo == 4'd9) begin
          inc_mo = 4'd0;
          if (live_mt == 4'd5) begin
            inc_mt   = 4'd0;
            inc_wrap = 1'b1;
          end else begin
            inc_mt = live_mt + 4'd1;
          end
        end else begin
          inc_mo = live_mo + 4'd1;
        end
      end else begin
        inc_st = live_st + 4'd1;
      end
    end
  end

  // Counting uses the state before any start transition in the same cycle.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      running  <= 1'b0;
      rollover <= 1'b0;
      presc    <= '0;
      live_so  <= 4'd0;
      live_st  <= 4'd0;
      live_mo  <= 4'd0;
      live_mt  <= 4'd0;
    end else if (clear_edge) begin
      state    <= IDLE;
      running  <= 1'b0;
      rollover <= 1'b0;
      presc    <= '0;
      live_so  <= 4'd0;
      live_st  <= 4'd0;
      live_mo  <= 4'd0;
      live_mt  <= 4'd0;
    end else begin
      rollover <= 1'b0;
      if (state == RUN && tick) begin
        if (presc == PRESC_MAX) begin
          presc    <= '0;
          live_so  <= inc_so;
          live_st  <= inc_st;
          live_mo  <= inc_mo;
          live_mt  <= inc_mt;
          rollover <= inc_wrap;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (start_edge) begin
        case (state)
          IDLE:    begin state <= RUN;   running <= 1'b1; end
          RUN:     begin state <= PAUSE; running <= 1'b0; end
          PAUSE:   begin state <= RUN;   running <= 1'b1; end
          default: begin state <= IDLE;  running <= 1'b0; end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        lap_hist;
  logic        hold;
  logic [15:0] snap;
  logic        lap_edge;

  assign lap_edge = lap & ~lap_hist;

  // Snapshot is frozen on the edge that sets hold; counting continues underneath.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      lap_hist <= 1'b0;
      hold     <= 1'b0;
      snap     <= '0;
    end else begin
      lap_hist <= lap;
      if (clear_edge) begin
        hold <= 1'b0;
      end else if (lap_edge && state != IDLE) begin
        hold <= ~hold;
        if (!hold) snap <= {live_mt, live_mo, live_st, live_so};
      end
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} =
    hold ? snap : {live_mt, live_mo, live_st, live_so};
`else
  assign sec_ones = live_so;
  assign sec_tens = live_st;
  assign min_ones = live_mo;
  assign min_tens = live_mt;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd: one instance at 1 tick/s, one at 4 ticks/s.
module tb_stopwatch_bcd;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  logic slow_a = 1'b0, start_a = 1'b0, clear_a = 1'b0;
  logic slow_b = 1'b0, start_b = 1'b0, clear_b = 1'b0;
  logic lap = 1'b0;

  logic [3:0] so_a, st_a, mo_a, mt_a, so_b, st_b, mo_b, mt_b;
  logic       running_a, rollover_a, running_b, rollover_b;

  int vectors = 0;
  int miscompares = 0;

  wire [15:0] time_a = {mt_a, mo_a, st_a, so_a};
  wire [15:0] time_b = {mt_b, mo_b, st_b, so_b};

  always #5 clkin = ~clkin;

  stopwatch_bcd #(.SYNC_STAGES(2), .TICKS_PER_SEC(1)) dut_a (
    .clkin(clkin), .reset(reset), .slow_clk(slow_a),
    .start_stop(start_a), .clear(clear_a),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so_a), .sec_tens(st_a), .min_ones(mo_a), .min_tens(mt_a),
    .running(running_a), .rollover(rollover_a)
  );

  stopwatch_bcd #(.SYNC_STAGES(2), .TICKS_PER_SEC(4)) dut_b (
    .clkin(clkin), .reset(reset), .slow_clk(slow_b),
    .start_stop(start_b), .clear(clear_b),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so_b), .sec_tens(st_b), .min_ones(mo_b), .min_tens(mt_b),
    .running(running_b), .rollover(rollover_b)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // One slow_clk period: two cycles high, two low; the digits settle before it returns.
  task automatic tick(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) slow_b = 1'b1; else slow_a = 1'b1;
      cycles(2);
      slow_a = 1'b0;
      slow_b = 1'b0;
      cycles(2);
    end
  endtask

  task automatic press_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    cycles(1);
    start_a = 1'b0;
    start_b = 1'b0;
    cycles(1);
  endtask

  task automatic press_clear(input bit b);
    if (b) clear_b = 1'b1; else clear_a = 1'b1;
    cycles(1);
    clear_a = 1'b0;
    clear_b = 1'b0;
    cycles(1);
  endtask

  initial begin
    #1 reset = 1'b0;
    cycles(2);
    check_output("reset_time", time_a, 16'h0000);
    check_output("reset_running", running_a, 1'b0);
    check_output("reset_rollover", rollover_a, 1'b0);
    reset = 1'b1;
    cycles(2);

    press_start(1'b0);
    check_output("start_running", running_a, 1'b1);
    slow_a = 1'b1;
    cycles(2);
    check_output("latency_edge2", time_a, 16'h0000);
    cycles(1);
    check_output("latency_edge3", time_a, 16'h0001);
    slow_a = 1'b0;
    cycles(2);
    tick(1'b0, 9);
    check_output("basic_0010", time_a, 16'h0010);

    press_clear(1'b0);
    check_output("clear_time", time_a, 16'h0000);
    check_output("clear_running", running_a, 1'b0);
    press_start(1'b0);
    tick(1'b0, 5);
    check_output("run_0005", time_a, 16'h0005);
    press_start(1'b0);
    tick(1'b0, 4);
    check_output("pause_hold", time_a, 16'h0005);
    check_output("pause_running", running_a, 1'b0);
    press_start(1'b0);
    tick(1'b0, 3);
    check_output("resume_0008", time_a, 16'h0008);
    check_output("resume_running", running_a, 1'b1);

    press_clear(1'b0);
    press_start(1'b0);
    tick(1'b0, 7);
    check_output("run_0007", time_a, 16'h0007);
    slow_a = 1'b1;
    cycles(2);
    start_a = 1'b1;
    slow_a = 1'b0;
    cycles(1);
    start_a = 1'b0;
    check_output("run_start_tick_time", time_a, 16'h0008);
    check_output("run_start_tick_state", running_a, 1'b0);
    cycles(3);
    slow_a = 1'b1;
    cycles(2);
    start_a = 1'b1;
    slow_a = 1'b0;
    cycles(1);
    start_a = 1'b0;
    check_output("pause_start_tick_time", time_a, 16'h0008);
    check_output("pause_start_tick_state", running_a, 1'b1);
    cycles(3);

    tick(1'b0, 193);
    check_output("run_0321", time_a, 16'h0321);
    start_a = 1'b1;
    clear_a = 1'b1;
    cycles(1);
    start_a = 1'b0;
    clear_a = 1'b0;
    cycles(1);
    check_output("clear_start_time", time_a, 16'h0000);
    check_output("clear_start_running", running_a, 1'b0);
    tick(1'b0, 1);
    check_output("idle_tick_ignored", time_a, 16'h0000);

    press_start(1'b0);
    tick(1'b0, 599);
    check_output("carry_0959", time_a, 16'h0959);
    tick(1'b0, 1);
    check_output("carry_1000", time_a, 16'h1000);
    tick(1'b0, 2999);
    check_output("run_5959", time_a, 16'h5959);
    slow_a = 1'b1;
    cycles(2);
    check_output("wrap_pre_rollover", rollover_a, 1'b0);
    cycles(1);
    check_output("wrap_time", time_a, 16'h0000);
    check_output("wrap_rollover", rollover_a, 1'b1);
    check_output("wrap_running", running_a, 1'b1);
    slow_a = 1'b0;
    cycles(1);
    check_output("wrap_rollover_end", rollover_a, 1'b0);
    cycles(1);

    tick(1'b0, 754);
    check_output("run_1234", time_a, 16'h1234);
    reset = 1'b0;
    #1;
    check_output("midreset_time", time_a, 16'h0000);
    check_output("midreset_running", running_a, 1'b0);
    check_output("midreset_rollover", rollover_a, 1'b0);
    cycles(2);
    reset = 1'b1;
    cycles(1);
    tick(1'b0, 3);
    check_output("postreset_idle", time_a, 16'h0000);
    check_output("postreset_running", running_a, 1'b0);

    press_start(1'b1);
    tick(1'b1, 8);
    check_output("presc_0002", time_b, 16'h0002);
    press_clear(1'b1);
    press_start(1'b1);
    tick(1'b1, 2);
    press_start(1'b1);
    tick(1'b1, 5);
    check_output("presc_paused", time_b, 16'h0000);
    check_output("presc_paused_running", running_b, 1'b0);
    press_start(1'b1);
    tick(1'b1, 1);
    check_output("presc_three_ticks", time_b, 16'h0000);
    tick(1'b1, 1);
    check_output("presc_0001", time_b, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
